// File: rtl/nand_flash_ctrl.sv
// nand_flash_ctrl
//   Host-side initiator for the on-chip NAND flash byte array. Turns page-level
//   READ / PROGRAM / ERASE commands into byte-wise array cycles with flash
//   semantics: program can only clear bits (new value ANDed with old), erase sets
//   a whole block to all-ones.
//
//   Optional feature macro: NAND_FLASH_CTRL_VERIFY_EN
//     defined   : every programmed byte is read back (PG_VISS/PG_VCAP) and a
//                 readback that differs from the written value raises op_err.
//     undefined : no readback; op_err comes only from bit-set attempts or an
//                 illegal opcode.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_op                         00 READ, 01 PROGRAM, 10 ERASE, 11 illegal
//   cmd_page                       target page (ERASE aligns down to its block)
//   wr_valid/wr_ready/wr_data      program data stream, one byte per handshake
//   rd_valid/rd_ready/rd_data      read data stream, byte held until accepted
//   op_done/op_err                 one-cycle completion pulse + error qualifier
//   mem_we/mem_re/mem_addr         array strobes and byte address {page, offset}
//   mem_wdata/mem_rdata            array write data / registered read data
//                                  (1-cycle latency, 0 when re was low)

module nand_flash_ctrl #(
  parameter  int ADDR_W      = 8,
  parameter  int DATA_W      = 8,
  parameter  int PAGE_BYTES  = 16,
  parameter  int BLOCK_PAGES = 4,
  localparam int OFF_W       = $clog2(PAGE_BYTES),
  localparam int PAGE_W      = ADDR_W - OFF_W,
  localparam int BLK_W       = $clog2(BLOCK_PAGES),
  localparam int CNT_W       = $clog2(PAGE_BYTES * BLOCK_PAGES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [PAGE_W-1:0] cmd_page,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              op_done,
  output logic              op_err,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] RD_ISS  = 4'd1;
  localparam logic [3:0] RD_CAP  = 4'd2;
  localparam logic [3:0] RD_OUT  = 4'd3;
  localparam logic [3:0] PG_WAIT = 4'd4;
  localparam logic [3:0] PG_ISS  = 4'd5;
  localparam logic [3:0] PG_CAP  = 4'd6;
  localparam logic [3:0] PG_WR   = 4'd7;
`ifdef NAND_FLASH_CTRL_VERIFY_EN
  localparam logic [3:0] PG_VISS = 4'd8;
  localparam logic [3:0] PG_VCAP = 4'd9;
`endif
  localparam logic [3:0] ER_WR   = 4'd10;
  localparam logic [3:0] DONE    = 4'd11;

  logic [3:0]        state;
  logic [PAGE_W-1:0] page_q;
  logic [CNT_W-1:0]  off;
  logic [DATA_W-1:0] wbyte;    // host byte for the current program step
  logic [DATA_W-1:0] old_q;    // array contents before the program step
  logic [DATA_W-1:0] rd_q;
  logic              err;      // sticky until DONE
  logic              page_last;
  logic              blk_last;
  logic [DATA_W-1:0] pg_val;   // value actually written: flash can only clear bits
  logic [ADDR_W-1:0] addr;

  // Read/program walk one page (low OFF_W bits of the counter); erase walks the
  // whole block with the full counter. Terminal count ends the walk, so the
  // counter never wraps into the next page or block.
  assign page_last = (off[OFF_W-1:0] == {OFF_W{1'b1}});
  assign blk_last  = (off == {CNT_W{1'b1}});
  assign pg_val    = old_q & wbyte;

  // Erase drops the low BLK_W page bits, which aligns to the block base; the
  // counter's upper bits then select the page inside the block.
  always_comb begin
    if (state == ER_WR) addr = {page_q[PAGE_W-1:BLK_W], off};
    else                addr = {page_q, off[OFF_W-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      page_q <= '0;
      off    <= '0;
      wbyte  <= '0;
      old_q  <= '0;
      rd_q   <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          page_q <= cmd_page;
          off    <= '0;
          case (cmd_op)
            2'b00:   state <= RD_ISS;
            2'b01:   state <= PG_WAIT;
            2'b10:   state <= ER_WR;
            default: begin
              err   <= 1'b1;
              state <= DONE;
            end
          endcase
        end
        RD_ISS: state <= RD_CAP;
        RD_CAP: begin
          rd_q  <= mem_rdata;
          state <= RD_OUT;
        end
        RD_OUT: if (rd_ready) begin
          if (page_last) state <= DONE;
          else begin
            off   <= off + CNT_W'(1);
            state <= RD_ISS;
          end
        end
        PG_WAIT: if (wr_valid) begin
          wbyte <= wr_data;
          state <= PG_ISS;
        end
        PG_ISS: state <= PG_CAP;
        PG_CAP: begin
          old_q <= mem_rdata;
          // Asking for a 0->1 transition is an error, but the AND-write still
          // goes ahead so the page reflects what flash would actually hold.
          if ((wbyte & ~mem_rdata) != '0) err <= 1'b1;
          state <= PG_WR;
        end
`ifdef NAND_FLASH_CTRL_VERIFY_EN
        PG_WR:   state <= PG_VISS;
        PG_VISS: state <= PG_VCAP;
        PG_VCAP: begin
          if (mem_rdata != pg_val) err <= 1'b1;
          if (page_last) state <= DONE;
          else begin
            off   <= off + CNT_W'(1);
            state <= PG_WAIT;
          end
        end
`else
        PG_WR: begin
          if (page_last) state <= DONE;
          else begin
            off   <= off + CNT_W'(1);
            state <= PG_WAIT;
          end
        end
`endif
        ER_WR: begin
          if (blk_last) state <= DONE;
          else          off   <= off + CNT_W'(1);
        end
        DONE: begin
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset clears them in the
  // same cycle. The strobes are one-hot by construction: re only in *_ISS,
  // we only in PG_WR / ER_WR.
  always_comb begin
    mem_re = 1'b0;
    mem_we = 1'b0;
    case (state)
      RD_ISS, PG_ISS: mem_re = 1'b1;
`ifdef NAND_FLASH_CTRL_VERIFY_EN
      PG_VISS:        mem_re = 1'b1;
`endif
      PG_WR, ER_WR:   mem_we = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    mem_wdata = '0;
    if (state == ER_WR)      mem_wdata = {DATA_W{1'b1}};
    else if (state == PG_WR) mem_wdata = pg_val;
  end

  assign mem_addr  = (mem_we | mem_re) ? addr : '0;
  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == PG_WAIT);
  assign rd_valid  = (state == RD_OUT);
  assign rd_data   = rd_q;
  assign op_done   = (state == DONE);
  assign op_err    = (state == DONE) & err;

endmodule

// File: tb/tb_nand_flash_ctrl.sv
// Directed bench for nand_flash_ctrl with a behavioural 256-byte array model
// (registered read data, 1-cycle latency, 0 when re low).

module tb_nand_flash_ctrl;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid, cmd_ready;
  logic [1:0]       cmd_op;
  logic [3:0]       cmd_page;
  logic             wr_valid, wr_ready;
  logic [7:0]       wr_data;
  logic             rd_valid, rd_ready;
  logic [7:0]       rd_data;
  logic             op_done, op_err;
  logic             mem_we, mem_re;
  logic [7:0]       mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  nand_flash_ctrl #(
    .ADDR_W(8), .DATA_W(8), .PAGE_BYTES(16), .BLOCK_PAGES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_page(cmd_page),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .op_done(op_done), .op_err(op_err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // array model + activity counters
  logic [7:0] mem [256];
  int         we_cnt = 0;
  int         re_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] last_we_addr = 8'h00;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt++;
      last_we_addr = mem_addr;
    end
    if (mem_re) re_cnt++;
    if (mem_we && mem_re) both_cnt++;
    mem_rdata <= mem_re ? mem[mem_addr] : 8'h00;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] pg);
    int t;
    t = 0;
    while (!cmd_ready && t < 200) begin tick(); t++; end
    if (t >= 200) chk("cmd_ready_to", t, 0);
    cmd_valid = 1'b1; cmd_op = op; cmd_page = pg;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output logic e, output int lat);
    int t;
    t = 0;
    while (!op_done && t < 300) begin tick(); t++; end
    chk("done_to", 32'(t < 300), 1);
    e = op_err;
    lat = t;
    tick();
  endtask

  task automatic prog(input logic [3:0] pg, input logic [15:0][7:0] d, output logic e);
    int t, lat;
    issue(2'b01, pg);
    for (int i = 0; i < 16; i++) begin
      t = 0;
      wr_valid = 1'b1; wr_data = d[i];
      while (!wr_ready && t < 50) begin tick(); t++; end
      if (t >= 50) chk("wr_ready_to", t, 0);
      tick();
      wr_valid = 1'b0;
    end
    wait_done(e, lat);
  endtask

  task automatic rd(input logic [3:0] pg, input int hold_idx, output logic [15:0][7:0] q,
                    output logic e);
    int t, lat, re0, bad;
    issue(2'b00, pg);
    for (int i = 0; i < 16; i++) begin
      t = 0;
      while (!rd_valid && t < 50) begin tick(); t++; end
      if (t >= 50) chk("rd_valid_to", t, 0);
      q[i] = rd_data;
      if (i == hold_idx) begin
        re0 = re_cnt; bad = 0;
        for (int k = 0; k < 10; k++) begin
          tick();
          if (!rd_valid || rd_data !== q[i] || mem_re) bad++;
        end
        chk("hold_stable", bad, 0);
        chk("hold_no_re", re_cnt - re0, 0);
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    wait_done(e, lat);
  endtask

  logic [15:0][7:0] d, q;
  logic             e;
  int               lat, w0, r0, cnt;

  initial begin
    cmd_valid = 0; cmd_op = 0; cmd_page = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    for (int i = 0; i < 256; i++) mem[i] <= 8'hA5;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", 32'({mem_we, mem_re, mem_addr, mem_wdata, rd_valid, rd_data,
                         op_done, op_err, wr_ready}), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    rst_n = 1'b1;
    tick();

    // 1: reset in the middle of an erase of block 3
    issue(2'b10, 4'd13);
    repeat (5) tick();
    chk("t1_erasing", 32'(mem_we), 1);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_outs", 32'({mem_we, mem_re, mem_addr, mem_wdata, rd_valid, rd_data,
                            op_done, op_err, wr_ready}), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t1_cmd_ready", 32'(cmd_ready), 1);
    w0 = we_cnt; cnt = 0;
    repeat (80) begin tick(); if (op_done) cnt++; end
    chk("t1_no_done", cnt, 0);
    chk("t1_no_we", we_cnt - w0, 0);

    // 2: erase page 5 -> block 1 = 0x40..0x7F
    w0 = we_cnt;
    issue(2'b10, 4'd5);
    wait_done(e, lat);
    chk("t2_err", 32'(e), 0);
    chk("t2_lat", lat, 64);
    chk("t2_we_cnt", we_cnt - w0, 64);
    cnt = 0;
    for (int a = 64; a < 128; a++) if (mem[a] !== 8'hFF) cnt++;
    chk("t2_not_ff", cnt, 0);
    chk("t2_below", 32'(mem[63]), 32'h A5);
    chk("t2_above", 32'(mem[128]), 32'h A5);
    chk("t2_last_addr", 32'(last_we_addr), 32'h7F);

    // 3: program page 4 with 0x00..0x0F, then read it back
    for (int i = 0; i < 16; i++) d[i] = 8'(i);
    prog(4'd4, d, e);
    chk("t3_prog_err", 32'(e), 0);
    rd(4'd4, -1, q, e);
    chk("t3_rd_err", 32'(e), 0);
    for (int i = 0; i < 16; i++) chk($sformatf("t3_rd%0d", i), 32'(q[i]), i);

    // 4: program 0xFF on top -> contents unchanged, bit-set error
    for (int i = 0; i < 16; i++) d[i] = 8'hFF;
    prog(4'd4, d, e);
    chk("t4_err", 32'(e), 1);
    cnt = 0;
    for (int i = 0; i < 16; i++) if (mem[64 + i] !== 8'(i)) cnt++;
    chk("t4_unchanged", cnt, 0);

    // 5: read with the host stalling on byte 3
    rd(4'd4, 3, q, e);
    chk("t5_err", 32'(e), 0);
    for (int i = 0; i < 16; i++) chk($sformatf("t5_rd%0d", i), 32'(q[i]), i);

    // clear-only program on erased page 5, then a bit-setting one
    for (int i = 0; i < 16; i++) d[i] = 8'h5A;
    prog(4'd5, d, e);
    chk("t7_err", 32'(e), 0);
    for (int i = 0; i < 16; i++) d[i] = 8'h0F;
    prog(4'd5, d, e);
    chk("t7b_err", 32'(e), 1);
    cnt = 0;
    for (int i = 0; i < 16; i++) if (mem[80 + i] !== 8'h0A) cnt++;
    chk("t7b_and", cnt, 0);

    // 6: illegal opcode
    w0 = we_cnt; r0 = re_cnt;
    issue(2'b11, 4'd2);
    wait_done(e, lat);
    chk("t6_lat", lat, 0);
    chk("t6_err", 32'(e), 1);
    chk("t6_no_we", we_cnt - w0, 0);
    chk("t6_no_re", re_cnt - r0, 0);
    chk("t6_ready", 32'(cmd_ready), 1);

    chk("we_re_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
